// File: rtl/tpu_mmio_ctrl.sv
// Memory-mapped control block for the TPU: decodes host requests into memory load strobes
// and sequences a counted multiply. Optional cycle counter enabled by `define TPU_CYCLE_COUNT_EN.
module tpu_mmio_ctrl #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64,
  localparam int CW     = DIM * BITS_C / DATAW,
  localparam int RW     = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int CWW    = (CW > 1) ? $clog2(CW) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    r_w,
  input  logic [ADDRW-1:0]        addr,
  input  logic [DIM*BITS_C-1:0]   c_rowdata,
  output logic                    rdy,
  output logic [DATAW-1:0]        dataOut,
  output logic                    rd_valid,
  output logic                    a_we,
  output logic                    b_en,
  output logic                    c_we,
  output logic [RW-1:0]           a_row,
  output logic [RW-1:0]           c_row,
  output logic [CWW-1:0]          c_word,
  output logic                    sys_en,
  output logic                    busy,
  output logic                    done_irq
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  localparam int            MUL_CYCLES = 3 * DIM - 2;
  localparam int            MCW        = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MCW-1:0] MUL_LAST  = MCW'(MUL_CYCLES - 1);

  // One A/B row is one bus word; C rows span CW bus words.
  localparam logic [31:0] ROW_BYTES   = 32'(DIM * BITS_AB / 8);
  localparam logic [31:0] A_BASE      = 32'h0100;
  localparam logic [31:0] B_BASE      = 32'h0200;
  localparam logic [31:0] C_BASE      = 32'h0300;
  localparam logic [31:0] START_ADDR  = 32'h0400;
  localparam logic [31:0] STATUS_ADDR = 32'h0408;
  localparam logic [31:0] A_END       = A_BASE + 32'(DIM) * ROW_BYTES;
  localparam logic [31:0] B_END       = B_BASE + 32'(DIM) * ROW_BYTES;
  localparam logic [31:0] C_END       = C_BASE + 32'(DIM * CW * DATAW / 8);

  state_e           state_q, state_d;
  logic [MCW-1:0]   cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             sys_en_q, sys_en_d;
  logic             busy_q, busy_d;
  logic             done_irq_q, done_irq_d;
  logic [DATAW-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;

  logic [31:0]      addr_w, c_idx;
  logic             aligned, hit_a, hit_b, hit_c, hit_start, hit_status, hit_cnt;
  logic             rd_acc, wr_acc, start_acc, status_rd;
  logic [DATAW-1:0] rd_data;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    addr_w     = 32'(addr);
    aligned    = (addr[2:0] == 3'b000);
    hit_a      = aligned && (addr_w >= A_BASE) && (addr_w < A_END);
    hit_b      = aligned && (addr_w >= B_BASE) && (addr_w < B_END);
    hit_c      = aligned && (addr_w >= C_BASE) && (addr_w < C_END);
    hit_start  = (addr_w == START_ADDR);
    hit_status = (addr_w == STATUS_ADDR);
`ifdef TPU_CYCLE_COUNT_EN
    hit_cnt    = (addr_w == 32'h0410);
`else
    hit_cnt    = 1'b0;
`endif
    c_idx      = (addr_w - C_BASE) >> 3;
  end

  // Reads are never stalled; every write class is held off while a multiply runs.
  assign rdy       = !(req && r_w && busy_q);
  assign rd_acc    = req && !r_w;
  assign wr_acc    = req && r_w && !busy_q;
  assign start_acc = wr_acc && hit_start;
  assign status_rd = rd_acc && hit_status;

  assign a_we   = wr_acc && hit_a;
  assign b_en   = wr_acc && hit_b;
  assign c_we   = wr_acc && hit_c;
  assign a_row  = RW'((addr_w - A_BASE) >> 3);
  assign c_row  = RW'(c_idx / CW);
  assign c_word = CWW'(c_idx % CW);

`ifdef TPU_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (wr_acc && hit_cnt)
      cyc_cnt_d = '0;
    else if (sys_en_q && (cyc_cnt_q != 32'hFFFF_FFFF))
      cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_cnt_q <= '0;
    else        cyc_cnt_q <= cyc_cnt_d;
  end
`endif

  always_comb begin
    rd_data = '0;
    if (hit_c)
      rd_data = c_rowdata[int'(c_word) * DATAW +: DATAW];
    else if (hit_status)
      rd_data = DATAW'({busy_q, done_q});
`ifdef TPU_CYCLE_COUNT_EN
    else if (hit_cnt)
      rd_data = DATAW'(cyc_cnt_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_acc) begin
        state_d = MUL;
        cnt_d   = '0;
      end
      MUL: if (cnt_q == MUL_LAST) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // START clears done ahead of everything; a completion outranks a status-read clear
    // so a finish landing on the same cycle as the read is not lost.
    done_d = done_q;
    if (start_acc)
      done_d = 1'b0;
    else if (state_q == MUL && cnt_q == MUL_LAST)
      done_d = 1'b1;
    else if (status_rd)
      done_d = 1'b0;

    sys_en_d   = (state_d == MUL);
    busy_d     = (state_d != IDLE);
    done_irq_d = (state_d == DONE);
    rd_valid_d = rd_acc;
    data_out_d = rd_acc ? rd_data : data_out_q;
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      sys_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_irq_q <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      sys_en_q   <= sys_en_d;
      busy_q     <= busy_d;
      done_irq_q <= done_irq_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign sys_en   = sys_en_q;
  assign busy     = busy_q;
  assign done_irq = done_irq_q;
  assign dataOut  = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_tpu_mmio_ctrl.sv
// Scoreboard bench for tpu_mmio_ctrl (DIM=8, CW=2): read expectations are queued at issue
// and popped by a monitor on each rd_valid; strobes and multiply timing are checked directly.
module tb_tpu_mmio_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         r_w = 1'b0;
  logic [15:0]  addr = '0;
  logic [127:0] c_rowdata;
  logic         rdy, rd_valid, a_we, b_en, c_we, sys_en, busy, done_irq;
  logic [63:0]  dataOut;
  logic [2:0]   a_row, c_row;
  logic         c_word;

  tpu_mmio_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .addr(addr),
    .c_rowdata(c_rowdata), .rdy(rdy), .dataOut(dataOut), .rd_valid(rd_valid),
    .a_we(a_we), .b_en(b_en), .c_we(c_we), .a_row(a_row), .c_row(c_row),
    .c_word(c_word), .sys_en(sys_en), .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  // Array model: word w of row r is 0xC000..00_rr_0w, except row 0 word 1 = 0xDEAD.
  always_comb begin
    c_rowdata = '0;
    for (int w = 0; w < 2; w++)
      c_rowdata[w*64 +: 64] = 64'hC000_0000_0000_0000 | (64'(c_row) << 8) | 64'(w);
    if (c_row == 3'd0) c_rowdata[127:64] = 64'h0000_0000_0000_DEAD;
  end

  typedef struct { string name; logic [63:0] data; } exp_t;
  exp_t exp_q[$];

  int n_total = 0, n_pass = 0;
  int cyc = 0;
  int sys_cnt = 0, irq_cnt = 0, irq_cyc = 0, rd_pulses = 0, bad_strobe = 0;
  int n_reads = 0;
  int acc_cyc, wait_n;
  logic snap_a_we, snap_b_en, snap_c_we, snap_c_word;
  logic [2:0] snap_a_row, snap_c_row;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every read return and tracks multiply activity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        rd_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.name, dataOut, e.data);
        end
      end
      if (sys_en) sys_cnt++;
      if (done_irq) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
      if ((a_we || b_en || c_we) && busy) bad_strobe++;
    end
  end

  // Entered and left one time unit after a rising edge. Holds req until accepted.
  task automatic issue(input bit w, input logic [15:0] a, input string name,
                       input logic [63:0] exp_rd);
    req = 1'b1; r_w = w; addr = a; wait_n = 0;
    @(negedge clk);
    while (!rdy && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (!rdy) check({name, "_rdy_timeout"}, 64'(rdy), 64'd1);
    acc_cyc = cyc;
    snap_a_we = a_we; snap_b_en = b_en; snap_c_we = c_we;
    snap_a_row = a_row; snap_c_row = c_row; snap_c_word = c_word;
    if (!w) begin
      exp_q.push_back('{name, exp_rd});
      n_reads++;
    end
    @(posedge clk);
    #1 req = 1'b0; r_w = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] CNT_AFTER_TWO =
`ifdef TPU_CYCLE_COUNT_EN
    64'd44;
`else
    64'd0;
`endif

  int start_cyc, sys_base, irq_base;

  initial begin
    #2;
    check("rst_rdy", 64'(rdy), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_dataOut", dataOut, 64'd0);
    check("rst_busy_sys_irq", {61'd0, busy, sys_en, done_irq}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 16'h0408, "status_after_reset", 64'd0);

    issue(1, 16'h0118, "wr_a", 64'd0);
    check("wr_a_strobes", {61'd0, snap_a_we, snap_b_en, snap_c_we}, 64'b100);
    check("wr_a_row", 64'(snap_a_row), 64'd3);
    @(negedge clk);
    check("wr_a_single", 64'(a_we), 64'd0);
    @(posedge clk); #1;

    issue(1, 16'h0208, "wr_b", 64'd0);
    check("wr_b_strobes", {61'd0, snap_a_we, snap_b_en, snap_c_we}, 64'b010);

    issue(1, 16'h0318, "wr_c", 64'd0);
    check("wr_c_strobes", {61'd0, snap_a_we, snap_b_en, snap_c_we}, 64'b001);
    check("wr_c_row_word", {60'd0, snap_c_row, snap_c_word}, {60'd0, 3'd1, 1'b1});
    @(negedge clk);
    check("wr_c_single", 64'(c_we), 64'd0);
    @(posedge clk); #1;

    issue(1, 16'h0600, "wr_unmapped", 64'd0);
    check("wr_unmapped_strobes", {61'd0, snap_a_we, snap_b_en, snap_c_we}, 64'b000);

    // Multiply 1: sys_en window, irq timing, stalled write, reads accepted while busy.
    sys_base = sys_cnt; irq_base = irq_cnt;
    issue(1, 16'h0400, "start1", 64'd0);
    start_cyc = acc_cyc;
    issue(0, 16'h0408, "status_busy", 64'd2);
    check("rd_not_stalled", 64'(wait_n), 64'd0);
    repeat (3) @(posedge clk);
    #1 check("stall_issue_cycle", 64'(cyc - start_cyc), 64'd5);
    issue(1, 16'h0100, "wr_a_stalled", 64'd0);
    check("stall_release_cycle", 64'(acc_cyc - start_cyc), 64'd24);
    check("stalled_a_we", 64'(snap_a_we), 64'd1);
    check("sys_en_cycles", 64'(sys_cnt - sys_base), 64'd22);
    check("irq_count", 64'(irq_cnt - irq_base), 64'd1);
    check("irq_cycle", 64'(irq_cyc - start_cyc), 64'd23);

    issue(0, 16'h0408, "status_done", 64'd1);
    issue(0, 16'h0408, "status_cleared", 64'd0);

    // Multiply 2, then the cycle counter and its clear.
    issue(1, 16'h0400, "start2", 64'd0);
    wait_idle();
    issue(0, 16'h0410, "cnt_two_muls", CNT_AFTER_TWO);
    issue(1, 16'h0410, "cnt_clear", 64'd0);
    issue(0, 16'h0410, "cnt_after_clear", 64'd0);

    // Multiply 3 starts with done still set: START must clear it.
    issue(1, 16'h0400, "start3", 64'd0);
    issue(0, 16'h0408, "status_start_clears", 64'd2);
    wait_idle();
    issue(0, 16'h0408, "status_done3", 64'd1);

    issue(0, 16'h0500, "rd_unmapped", 64'd0);
    issue(0, 16'h0318, "rd_c_r1w1", 64'hC000_0000_0000_0101);
    issue(0, 16'h0300, "rd_c_r0w0", 64'hC000_0000_0000_0000);
    issue(0, 16'h0308, "rd_c_dead", 64'h0000_0000_0000_DEAD);
    repeat (4) @(posedge clk);
    #1 check("dataOut_holds", dataOut, 64'h0000_0000_0000_DEAD);
    check("rd_valid_drops", 64'(rd_valid), 64'd0);

    // Reset in the middle of a multiply.
    issue(1, 16'h0400, "start4", 64'd0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_state", {60'd0, busy, sys_en, done_irq, rd_valid}, 64'd0);
    check("midrst_dataOut", dataOut, 64'd0);
    check("midrst_rdy", 64'(rdy), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 16'h0408, "status_after_midrst", 64'd0);
    issue(0, 16'h0410, "cnt_after_midrst", 64'd0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("rd_valid_pulses", 64'(rd_pulses), 64'(n_reads));
    check("no_strobe_while_busy", 64'(bad_strobe), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
